// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//   Memory/writeback stage of the in-order RV32I pipeline. It takes the
//   registered execute results. A load/store is turned into a data-memory
//   request that is held stable until dmem_resp_i, and upstream is stalled
//   meanwhile. Load data is aligned and extended, and a registered
//   register-file write is produced.
//
// Ports
//   clk_i, rst_n_i        clock (rising edge), async active-low reset
//   valid_i .. rd_wr_i    execute-stage result and memory request fields
//   ready_o               1 = stage can accept (IDLE), 0 = stall upstream
//   dmem_addr_o/rmask_o/wmask_o/wdata_o
//                         data-memory request, nonzero only while BUSY
//   dmem_rdata_i, dmem_resp_i
//                         memory read data and one-cycle response strobe
//   rd_wr_o, rd_addr_o, rd_wdata_o
//                         registered register-file write (rd_wr_o is a pulse)
//   commit_o              one-cycle pulse per retired instruction
//   stall_cnt_o           saturating count of cycles spent waiting in BUSY
// ---------------------------------------------------------------------------
module mem_wb_stage #(
   parameter int STALL_CNT_W = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   valid_i,
   input  logic                   load_i,
   input  logic                   store_i,
   input  logic [2:0]             funct3_i,
   input  logic [31:0]            alu_result_i,
   input  logic [31:0]            dmem_wdata_i,
   input  logic [3:0]             dmem_rmask_i,
   input  logic [3:0]             dmem_wmask_i,
   input  logic [4:0]             rd_addr_i,
   input  logic                   rd_wr_i,
   output logic                   ready_o,
   output logic [31:0]            dmem_addr_o,
   output logic [3:0]             dmem_rmask_o,
   output logic [3:0]             dmem_wmask_o,
   output logic [31:0]            dmem_wdata_o,
   input  logic [31:0]            dmem_rdata_i,
   input  logic                   dmem_resp_i,
   output logic                   rd_wr_o,
   output logic [4:0]             rd_addr_o,
   output logic [31:0]            rd_wdata_o,
   output logic                   commit_o,
   output logic [STALL_CNT_W-1:0] stall_cnt_o
);

   typedef enum logic {IDLE, BUSY} state_e;

   // RV32I load funct3 encodings
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   state_e                 state_q, state_d;
   logic [31:0]            addr_q, addr_d;
   logic [3:0]             rmask_q, rmask_d;
   logic [3:0]             wmask_q, wmask_d;
   logic [31:0]            wdata_q, wdata_d;
   logic [2:0]             funct3_q, funct3_d;
   logic [1:0]             offset_q, offset_d;
   logic [4:0]             req_rd_q, req_rd_d;
   logic                   req_wr_q, req_wr_d;
   logic                   load_q, load_d;
   logic                   rd_wr_q, rd_wr_d;
   logic [4:0]             rd_addr_q, rd_addr_d;
   logic [31:0]            rd_wdata_q, rd_wdata_d;
   logic                   commit_q, commit_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic        accept;
   logic        is_mem;
   logic        mem_req;
   logic        busy;
   logic [31:0] load_data;
   logic        load_ok;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   assign busy    = (state_q == BUSY);
   assign ready_o = (state_q == IDLE);
   assign accept  = valid_i && ready_o;
   assign is_mem  = load_i || store_i;
   assign mem_req = is_mem && ((dmem_rmask_i | dmem_wmask_i) != 4'b0000);

   // Gated by state so that an async reset drops the request immediately.
   assign dmem_addr_o  = busy ? addr_q  : 32'h0;
   assign dmem_rmask_o = busy ? rmask_q : 4'h0;
   assign dmem_wmask_o = busy ? wmask_q : 4'h0;
   assign dmem_wdata_o = busy ? wdata_q : 32'h0;

   assign rd_wr_o     = rd_wr_q;
   assign rd_addr_o   = rd_addr_q;
   assign rd_wdata_o  = rd_wdata_q;
   assign commit_o    = commit_q;
   assign stall_cnt_o = stall_cnt_q;

   // Load alignment: pick the addressed byte/half, then extend per funct3.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      sel_byte  = dmem_rdata_i[{offset_q, 3'b000} +: 8];
      sel_half  = offset_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
      load_data = 32'h0;
      load_ok   = 1'b1;
      case (funct3_q)
         F3_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
         F3_LBU:  load_data = {24'h0, sel_byte};
         F3_LH:   load_data = {{16{sel_half[15]}}, sel_half};
         F3_LHU:  load_data = {16'h0, sel_half};
         F3_LW:   load_data = dmem_rdata_i;
         default: load_ok   = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rmask_d     = rmask_q;
      wmask_d     = wmask_q;
      wdata_d     = wdata_q;
      funct3_d    = funct3_q;
      offset_d    = offset_q;
      req_rd_d    = req_rd_q;
      req_wr_d    = req_wr_q;
      load_d      = load_q;
      rd_wr_d     = 1'b0;
      rd_addr_d   = rd_addr_q;
      rd_wdata_d  = rd_wdata_q;
      commit_d    = 1'b0;
      stall_cnt_d = stall_cnt_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (mem_req) begin
                  addr_d   = {alu_result_i[31:2], 2'b00};
                  rmask_d  = dmem_rmask_i;
                  wmask_d  = dmem_wmask_i;
                  wdata_d  = dmem_wdata_i;
                  funct3_d = funct3_i;
                  offset_d = alu_result_i[1:0];
                  req_rd_d = rd_addr_i;
                  req_wr_d = rd_wr_i;
                  load_d   = load_i;
                  state_d  = BUSY;
               end else if (is_mem) begin
                  // Memory op with empty masks retires without writing rd.
                  commit_d = 1'b1;
               end else begin
                  commit_d   = 1'b1;
                  rd_wr_d    = rd_wr_i && (rd_addr_i != 5'd0);
                  rd_addr_d  = rd_addr_i;
                  rd_wdata_d = alu_result_i;
               end
            end
         end
         BUSY: begin
            if (dmem_resp_i) begin
               state_d  = IDLE;
               commit_d = 1'b1;
               if (load_q) begin
                  rd_addr_d  = req_rd_q;
                  rd_wdata_d = load_data;
                  rd_wr_d    = load_ok && req_wr_q && (req_rd_q != 5'd0);
               end
            end else if (stall_cnt_q != {STALL_CNT_W{1'b1}}) begin
               stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the held request registers are reset along with the state so an
   // abandoned request leaves nothing stale behind for the next one.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         rmask_q     <= '0;
         wmask_q     <= '0;
         wdata_q     <= '0;
         funct3_q    <= '0;
         offset_q    <= '0;
         req_rd_q    <= '0;
         req_wr_q    <= 1'b0;
         load_q      <= 1'b0;
         rd_wr_q     <= 1'b0;
         rd_addr_q   <= '0;
         rd_wdata_q  <= '0;
         commit_q    <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q     <= state_d;
         addr_q      <= addr_d;
         rmask_q     <= rmask_d;
         wmask_q     <= wmask_d;
         wdata_q     <= wdata_d;
         funct3_q    <= funct3_d;
         offset_q    <= offset_d;
         req_rd_q    <= req_rd_d;
         req_wr_q    <= req_wr_d;
         load_q      <= load_d;
         rd_wr_q     <= rd_wr_d;
         rd_addr_q   <= rd_addr_d;
         rd_wdata_q  <= rd_wdata_d;
         commit_q    <= commit_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
//   Directed bench for mem_wb_stage. Expected retirements are queued when an
//   instruction is driven and compared when commit_o pulses. The stall
//   counter is instantiated 4 bits wide so saturation is reachable.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

   localparam int CW = 4;

   logic          clk_i = 1'b0;
   logic          rst_n_i = 1'b0;
   logic          valid_i = 1'b0, load_i = 1'b0, store_i = 1'b0;
   logic [2:0]    funct3_i = '0;
   logic [31:0]   alu_result_i = '0, dmem_wdata_i = '0, dmem_rdata_i = '0;
   logic [3:0]    dmem_rmask_i = '0, dmem_wmask_i = '0;
   logic [4:0]    rd_addr_i = '0;
   logic          rd_wr_i = 1'b0, dmem_resp_i = 1'b0;
   logic          ready_o, rd_wr_o, commit_o;
   logic [31:0]   dmem_addr_o, dmem_wdata_o, rd_wdata_o;
   logic [3:0]    dmem_rmask_o, dmem_wmask_o;
   logic [4:0]    rd_addr_o;
   logic [CW-1:0] stall_cnt_o;

   mem_wb_stage #(.STALL_CNT_W(CW)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .load_i(load_i),
      .store_i(store_i), .funct3_i(funct3_i), .alu_result_i(alu_result_i),
      .dmem_wdata_i(dmem_wdata_i), .dmem_rmask_i(dmem_rmask_i),
      .dmem_wmask_i(dmem_wmask_i), .rd_addr_i(rd_addr_i), .rd_wr_i(rd_wr_i),
      .ready_o(ready_o), .dmem_addr_o(dmem_addr_o), .dmem_rmask_o(dmem_rmask_o),
      .dmem_wmask_o(dmem_wmask_o), .dmem_wdata_o(dmem_wdata_o),
      .dmem_rdata_i(dmem_rdata_i), .dmem_resp_i(dmem_resp_i), .rd_wr_o(rd_wr_o),
      .rd_addr_o(rd_addr_o), .rd_wdata_o(rd_wdata_o), .commit_o(commit_o),
      .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        wr;    // expected rd_wr_o
      logic        chk;   // compare rd_wdata_o
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   exp_stall = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk_i);
   endtask

   // Retirement monitor: every commit pops one scoreboard entry.
   always @(negedge clk_i) begin
      if (rst_n_i && commit_o) begin
         if (sb.size() == 0) begin
            check("unexpected_commit", 32'(commit_o), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rd_wr_o", 32'(rd_wr_o), 32'(e.wr));
            if (e.wr) check("rd_addr_o", 32'(rd_addr_o), 32'(e.addr));
            if (e.chk) check("rd_wdata_o", rd_wdata_o, e.data);
         end
      end else begin
         check("rd_wr_without_commit", 32'(rd_wr_o), 32'd0);
      end
   end

   task automatic alu_op(input logic [4:0] rd, input logic wr, input logic [31:0] res);
      exp_t e;
      check("alu_ready_before", 32'(ready_o), 32'd1);
      valid_i = 1'b1; load_i = 1'b0; store_i = 1'b0;
      rd_addr_i = rd; rd_wr_i = wr; alu_result_i = res;
      e.wr = wr && (rd != 5'd0); e.chk = e.wr; e.addr = rd; e.data = res;
      sb.push_back(e);
      step();
      valid_i = 1'b0;
      check("alu_commit", 32'(commit_o), 32'd1);
      check("alu_ready_after", 32'(ready_o), 32'd1);
   endtask

   // Drives one load/store, holds resp low for 'stalls' BUSY cycles, then
   // responds. With junk set, a non-memory op is offered during the stall.
   task automatic mem_op(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [3:0] rm, input logic [3:0] wm, input logic [31:0] wd,
                         input logic [4:0] rd, input logic wr, input int stalls,
                         input logic [31:0] rdata, input logic junk, input exp_t e);
      check("mem_ready_before", 32'(ready_o), 32'd1);
      valid_i = 1'b1; load_i = ld; store_i = !ld; funct3_i = f3;
      alu_result_i = addr; dmem_rmask_i = rm; dmem_wmask_i = wm; dmem_wdata_i = wd;
      rd_addr_i = rd; rd_wr_i = wr;
      sb.push_back(e);
      step();
      if (junk) begin
         load_i = 1'b0; store_i = 1'b0; alu_result_i = 32'h5555_5555;
         rd_addr_i = 5'd9; rd_wr_i = 1'b1; dmem_rmask_i = 4'hF; dmem_wmask_i = 4'hF;
         dmem_wdata_i = 32'hFFFF_FFFF;
      end else begin
         valid_i = 1'b0;
      end
      for (int i = 0; i <= stalls; i++) begin
         check("hold_addr", dmem_addr_o, addr & 32'hFFFF_FFFC);
         check("hold_rmask", 32'(dmem_rmask_o), 32'(rm));
         check("hold_wmask", 32'(dmem_wmask_o), 32'(wm));
         check("hold_wdata", dmem_wdata_o, wd);
         check("busy_ready", 32'(ready_o), 32'd0);
         if (i == stalls) begin
            valid_i = 1'b0; dmem_resp_i = 1'b1; dmem_rdata_i = rdata;
         end
         step();
      end
      dmem_resp_i = 1'b0;
      check("mem_commit_latency", 32'(commit_o), 32'd1);
      check("mem_ready_after", 32'(ready_o), 32'd1);
      check("mem_dmem_idle", 32'(dmem_rmask_o | dmem_wmask_o), 32'd0);
      exp_stall = exp_stall + stalls;
      if (exp_stall > (1 << CW) - 1) exp_stall = (1 << CW) - 1;
      check("stall_cnt", 32'(stall_cnt_o), 32'(exp_stall));
   endtask

   function automatic exp_t mk(input logic wr, input logic chk, input logic [4:0] a,
                               input logic [31:0] d);
      exp_t e;
      e.wr = wr; e.chk = chk; e.addr = a; e.data = d;
      return e;
   endfunction

   initial begin
      logic [4:0]  held_addr;
      logic [31:0] held_data;
      exp_t        e;

      // Reset state
      #1;
      check("rst_ready", 32'(ready_o), 32'd1);
      check("rst_rmask", 32'(dmem_rmask_o), 32'd0);
      check("rst_wmask", 32'(dmem_wmask_o), 32'd0);
      check("rst_addr", dmem_addr_o, 32'd0);
      check("rst_commit", 32'(commit_o), 32'd0);
      check("rst_rd_wdata", rd_wdata_o, 32'd0);
      check("rst_stall", 32'(stall_cnt_o), 32'd0);
      step();
      rst_n_i = 1'b1;
      step();

      // ADD result
      alu_op(5'd5, 1'b1, 32'h0000_1234);
      // ALU op targeting x0 retires without a write
      alu_op(5'd0, 1'b1, 32'h0000_0BAD);

      // LB sign-extension, 3 stall cycles, upstream keeps offering an op
      mem_op(1'b1, 3'b000, 32'h0000_1003, 4'h8, 4'h0, 32'h0, 5'd7, 1'b1, 3,
             32'h80FF_FFFF, 1'b1, mk(1'b1, 1'b1, 5'd7, 32'hFFFF_FF80));
      // LHU upper half, response in first BUSY cycle
      mem_op(1'b1, 3'b101, 32'h0000_2002, 4'hC, 4'h0, 32'h0, 5'd8, 1'b1, 0,
             32'hBEEF_0000, 1'b0, mk(1'b1, 1'b1, 5'd8, 32'h0000_BEEF));
      // SB store
      mem_op(1'b0, 3'b000, 32'h0000_0010, 4'h0, 4'h2, 32'h0000_AB00, 5'd0, 1'b0, 2,
             32'h0, 1'b0, mk(1'b0, 1'b0, 5'd0, 32'h0));
      // LW to x0
      mem_op(1'b1, 3'b010, 32'h0000_3000, 4'hF, 4'h0, 32'h0, 5'd0, 1'b1, 1,
             32'hDEAD_BEEF, 1'b0, mk(1'b0, 1'b0, 5'd0, 32'h0));

      // Stray response in IDLE
      held_addr = rd_addr_o;
      held_data = rd_wdata_o;
      dmem_resp_i = 1'b1; dmem_rdata_i = 32'h1111_1111;
      step();
      dmem_resp_i = 1'b0;
      check("stray_commit", 32'(commit_o), 32'd0);
      check("stray_ready", 32'(ready_o), 32'd1);
      check("stray_rd_addr", 32'(rd_addr_o), 32'(held_addr));
      check("stray_rd_wdata", rd_wdata_o, held_data);

      // Memory op with both masks zero retires immediately, no write
      check("zmask_ready", 32'(ready_o), 32'd1);
      valid_i = 1'b1; load_i = 1'b1; store_i = 1'b0; funct3_i = 3'b010;
      alu_result_i = 32'h40; dmem_rmask_i = 4'h0; dmem_wmask_i = 4'h0;
      rd_addr_i = 5'd13; rd_wr_i = 1'b1;
      e = mk(1'b0, 1'b0, 5'd0, 32'h0);
      sb.push_back(e);
      step();
      valid_i = 1'b0;
      check("zmask_commit", 32'(commit_o), 32'd1);
      check("zmask_ready_after", 32'(ready_o), 32'd1);
      check("zmask_rmask", 32'(dmem_rmask_o), 32'd0);

      // Unsupported load funct3 -> data 0, no write
      mem_op(1'b1, 3'b011, 32'h0000_0044, 4'hF, 4'h0, 32'h0, 5'd10, 1'b1, 0,
             32'h1234_5678, 1'b0, mk(1'b0, 1'b1, 5'd10, 32'h0));
      // LH signed lower half
      mem_op(1'b1, 3'b001, 32'h0000_0050, 4'h3, 4'h0, 32'h0, 5'd11, 1'b1, 0,
             32'h1234_8001, 1'b0, mk(1'b1, 1'b1, 5'd11, 32'hFFFF_8001));
      // LBU byte 1
      mem_op(1'b1, 3'b100, 32'h0000_0061, 4'h2, 4'h0, 32'h0, 5'd12, 1'b1, 0,
             32'h0000_F200, 1'b0, mk(1'b1, 1'b1, 5'd12, 32'h0000_00F2));
      // Long SW stall drives the counter into saturation
      mem_op(1'b0, 3'b010, 32'h0000_007C, 4'h0, 4'hF, 32'hCAFE_F00D, 5'd0, 1'b0, 12,
             32'h0, 1'b0, mk(1'b0, 1'b0, 5'd0, 32'h0));
      // Back-to-back ALU op right after a memory op
      alu_op(5'd31, 1'b1, 32'hA5A5_0001);

      // Reset mid-op
      valid_i = 1'b1; load_i = 1'b1; store_i = 1'b0; funct3_i = 3'b010;
      alu_result_i = 32'h80; dmem_rmask_i = 4'hF; dmem_wmask_i = 4'h0;
      rd_addr_i = 5'd14; rd_wr_i = 1'b1;
      step();
      valid_i = 1'b0;
      check("pre_rst_rmask", 32'(dmem_rmask_o), 32'hF);
      #2 rst_n_i = 1'b0;
      #1;
      check("async_rst_rmask", 32'(dmem_rmask_o), 32'd0);
      check("async_rst_ready", 32'(ready_o), 32'd1);
      check("async_rst_addr", dmem_addr_o, 32'd0);
      check("async_rst_stall", 32'(stall_cnt_o), 32'd0);
      step();
      rst_n_i = 1'b1;
      step();
      dmem_resp_i = 1'b1; dmem_rdata_i = 32'h7777_7777;
      step();
      dmem_resp_i = 1'b0;
      check("post_rst_commit", 32'(commit_o), 32'd0);
      check("post_rst_rd_wr", 32'(rd_wr_o), 32'd0);
      check("post_rst_rd_wdata", rd_wdata_o, 32'd0);
      step();
      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory/writeback stage sitting directly downstream of the execute unit in the in-order RV32I pipeline.
- Consumes the registered execute results (ALU result, data-memory address/masks/wdata, rd info, funct3, load/store flags) and drives the data-memory port.
- Holds each load/store request stable until dmem_resp_i, and stalls upstream meanwhile.
- Aligns and extends load data, and produces the registered register-file write for the decode/regfile stage.

Parameters:
- STALL_CNT_W, 32, width of the saturating memory-stall cycle counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- valid_i  in  1  execute-stage output valid.
- load_i  in  1  instruction is a load.
- store_i  in  1  instruction is a store.
- funct3_i  in  3  RV32I funct3 of the instruction.
- alu_result_i  in  32  execute result; also the effective address.
- dmem_wdata_i  in  32  store data, already lane-shifted.
- dmem_rmask_i  in  4  byte read mask.
- dmem_wmask_i  in  4  byte write mask.
- rd_addr_i  in  5  destination register.
- rd_wr_i  in  1  instruction writes rd.
- ready_o  out  1  stage can accept; 0 = stall upstream.
- dmem_addr_o  out  32  word-aligned data-memory address.
- dmem_rmask_o  out  4  read mask, held until response.
- dmem_wmask_o  out  4  write mask, held until response.
- dmem_wdata_o  out  32  write data, held until response.
- dmem_rdata_i  in  32  read data, valid with dmem_resp_i.
- dmem_resp_i  in  1  one-cycle memory response.
- rd_wr_o  out  1  register-file write enable, one-cycle pulse.
- rd_addr_o  out  5  register-file write address.
- rd_wdata_o  out  32  register-file write data.
- commit_o  out  1  one-cycle pulse per retired instruction.
- stall_cnt_o  out  STALL_CNT_W  cycles spent in BUSY, saturating.

Behaviour:
- Reset (async, rst_n_i=0): state IDLE; all outputs 0 immediately except ready_o=1. Request/held registers and stall_cnt_o are cleared.
- States: IDLE and BUSY.
- ready_o = (state==IDLE). An instruction is accepted when valid_i && ready_o.
- Accepted non-memory op (load_i=store_i=0), next edge:
  - commit_o=1.
  - rd_wr_o = rd_wr_i && rd_addr_i!=0.
  - rd_addr_o = rd_addr_i; rd_wdata_o = alu_result_i.
  - State stays IDLE. Latency 1 cycle.
- Accepted memory op with (rmask|wmask)!=0, next edge:
  - Latch address {alu_result_i[31:2],2'b00}, masks, wdata, funct3, byte offset alu_result_i[1:0], rd info, and the load flag.
  - Go to BUSY.
- Accepted memory op with both masks 0: treat as a non-memory op that writes nothing (rd_wr_o=0) and pulses commit_o.
- dmem_* outputs are driven only from the latched registers while in BUSY; they are 0 in IDLE. They are held constant for the whole of BUSY.
- BUSY with dmem_resp_i=0: stay in BUSY; stall_cnt_o += 1, saturating at all-ones.
- BUSY with dmem_resp_i=1, next edge:
  - Return to IDLE; commit_o=1.
  - For a load: rd_wr_o = rd_wr && rd_addr!=0, and rd_wdata_o = aligned load data.
  - For a store: rd_wr_o=0.
  - Minimum memory-op latency: accept edge + resp cycle = 2 edges.
- Load alignment, with byte offset o and data D=dmem_rdata_i:
  - LB: sign-extend D[8o+:8].
  - LBU: zero-extend D[8o+:8].
  - LH: sign-extend D[16*o[1]+:16].
  - LHU: zero-extend D[16*o[1]+:16].
  - LW: D.
  - Any other funct3: rd_wdata_o=0 and rd_wr_o=0.
- rd_wr_o and commit_o are single-cycle pulses. rd_addr_o and rd_wdata_o hold their last value until the next write.
- dmem_resp_i in IDLE is ignored: no write, no state change.
- valid_i while BUSY is not accepted; upstream holds it because ready_o=0.
- Reset asserted in BUSY: the request is abandoned and the masks drop to 0 asynchronously. A later stray dmem_resp_i is ignored.

Test Plan:
- ADD result: valid_i=1, load_i=store_i=0, rd_addr_i=5, rd_wr_i=1, alu_result_i=0x1234 -> next cycle rd_wr_o=1, rd_addr_o=5, rd_wdata_o=0x1234, commit_o=1, ready_o stays 1.
- LB sign-extension: addr 0x1003, rmask 0x8, rd=7; resp after 3 cycles with rdata 0x80FFFFFF.
  - -> dmem_addr_o=0x1000 and rmask 0x8 held 3 cycles; ready_o=0 during those cycles.
  - -> then rd_wdata_o=0xFFFFFF80, rd_wr_o=1; stall_cnt_o=3.
- LHU upper half: addr 0x2002, rmask 0xC, rdata 0xBEEF0000, resp in first BUSY cycle -> rd_wdata_o=0x0000BEEF, 2-edge latency.
- Store SB: wmask 0x2, wdata 0x0000AB00, addr 0x10 -> dmem_wmask_o=0x2, dmem_wdata_o=0x0000AB00 until resp; then commit_o=1, rd_wr_o=0.
- Write to x0 plus stray response: LW rd_addr_i=0, rdata 0xDEADBEEF -> rd_wr_o=0, commit_o=1; a dmem_resp_i=1 pulse in IDLE causes no output change.
- Reset mid-op: assert rst_n_i=0 while BUSY -> dmem masks=0 and ready_o=1 without waiting for a clock edge; a post-reset resp produces no write.
